// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS control unit: decodes op/funct, sequences FETCH..WB,
// handshakes with variable-latency memory and traps on illegal op or timeout.
module mc_ctrl_hs #(
    parameter int ALUOP_W  = 3,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_zero,
    input  logic [5:0]         i_op,
    input  logic [5:0]         i_funct,
    input  logic               i_mem_rdy,
    output logic               o_mem_req,
    output logic               o_mem_isd,
    output logic               o_pc_wr,
    output logic               o_ir_wr,
    output logic               o_rf_wr,
    output logic               o_dm_wr,
    output logic [1:0]         o_ext_op,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic [1:0]         o_npc_op,
    output logic [1:0]         o_gpr_sel,
    output logic [1:0]         o_wd_sel,
    output logic               o_b_sel,
    output logic               o_retire,
    output logic [1:0]         o_err
);

    localparam logic [3:0] S_FETCH = 4'd0;
    localparam logic [3:0] S_DCD   = 4'd1;
    localparam logic [3:0] S_EXE   = 4'd2;
    localparam logic [3:0] S_MA    = 4'd3;
    localparam logic [3:0] S_BR    = 4'd4;
    localparam logic [3:0] S_JMP   = 4'd5;
    localparam logic [3:0] S_MR    = 4'd6;
    localparam logic [3:0] S_MW    = 4'd7;
    localparam logic [3:0] S_WB    = 4'd8;
    localparam logic [3:0] S_MEMWB = 4'd9;
    localparam logic [3:0] S_TRAP  = 4'd10;

    logic [3:0]       r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d, w_cnt_inc;
    logic [1:0]       r_err, w_err_d;

    logic w_rtype, w_addu, w_subu, w_and, w_or, w_slt, w_jr, w_alu_r;
    logic w_ori, w_lui, w_lw, w_sw, w_beq, w_bne, w_j, w_jal;
    logic w_wait, w_timeout;

    assign w_rtype = (i_op == 6'b000000);
    assign w_addu  = w_rtype && (i_funct == 6'b100001);
    assign w_subu  = w_rtype && (i_funct == 6'b100011);
    assign w_and   = w_rtype && (i_funct == 6'b100100);
    assign w_or    = w_rtype && (i_funct == 6'b100101);
    assign w_slt   = w_rtype && (i_funct == 6'b101010);
    assign w_jr    = w_rtype && (i_funct == 6'b001000);
    assign w_alu_r = w_addu | w_subu | w_and | w_or | w_slt;
    assign w_ori   = (i_op == 6'b001101);
    assign w_lui   = (i_op == 6'b001111);
    assign w_lw    = (i_op == 6'b100011);
    assign w_sw    = (i_op == 6'b101011);
    assign w_beq   = (i_op == 6'b000100);
    assign w_bne   = (i_op == 6'b000101);
    assign w_j     = (i_op == 6'b000010);
    assign w_jal   = (i_op == 6'b000011);

    // The cycle whose incremented count reaches WAIT_MAX without rdy is the timeout.
    assign w_wait    = (r_state == S_FETCH) || (r_state == S_MR) || (r_state == S_MW);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = w_wait && !i_mem_rdy && (w_cnt_inc == CNT_W'(WAIT_MAX));

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = '0;
        w_err_d   = r_err;
        if (w_wait && !i_mem_rdy && !w_timeout) w_cnt_d = w_cnt_inc;
        case (r_state)
            S_FETCH: if (i_mem_rdy) w_state_d = S_DCD;
                     else if (w_timeout) w_state_d = S_TRAP;
            S_DCD: begin
                if (w_alu_r || w_ori || w_lui)      w_state_d = S_EXE;
                else if (w_lw || w_sw)              w_state_d = S_MA;
                else if (w_beq || w_bne)            w_state_d = S_BR;
                else if (w_j || w_jal || w_jr)      w_state_d = S_JMP;
                else begin
                    w_state_d = S_TRAP;
                    w_err_d   = 2'b01;
                end
            end
            S_EXE:   w_state_d = S_WB;
            S_MA:    w_state_d = w_lw ? S_MR : (w_sw ? S_MW : S_FETCH);
            S_MR:    if (i_mem_rdy) w_state_d = S_MEMWB;
                     else if (w_timeout) w_state_d = S_TRAP;
            S_MW:    if (i_mem_rdy) w_state_d = S_FETCH;
                     else if (w_timeout) w_state_d = S_TRAP;
            S_WB, S_MEMWB, S_BR, S_JMP: w_state_d = S_FETCH;
            S_TRAP:  w_state_d = S_TRAP;
            default: w_state_d = S_FETCH;
        endcase
        if (w_timeout) w_err_d = 2'b10;
        if (r_err != 2'b00) w_err_d = r_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
            r_err   <= 2'b00;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_err   <= w_err_d;
        end
    end

    always_comb begin
        o_mem_req = 1'b0;
        o_mem_isd = 1'b0;
        o_pc_wr   = 1'b0;
        o_ir_wr   = 1'b0;
        o_rf_wr   = 1'b0;
        o_dm_wr   = 1'b0;
        o_ext_op  = 2'd0;
        o_alu_op  = '0;
        o_npc_op  = 2'd0;
        o_gpr_sel = 2'd0;
        o_wd_sel  = 2'd0;
        o_b_sel   = 1'b0;
        o_retire  = 1'b0;
        o_err     = r_err;
        case (r_state)
            S_FETCH: begin
                o_mem_req = 1'b1;
                o_pc_wr   = i_mem_rdy;
                o_ir_wr   = i_mem_rdy;
            end
            S_EXE: begin
                o_b_sel  = w_ori | w_lui;
                o_ext_op = w_lui ? 2'd2 : 2'd0;
                if (w_ori)       o_alu_op = ALUOP_W'(3);
                else if (w_lui)  o_alu_op = ALUOP_W'(5);
                else if (w_subu) o_alu_op = ALUOP_W'(1);
                else if (w_and)  o_alu_op = ALUOP_W'(2);
                else if (w_or)   o_alu_op = ALUOP_W'(3);
                else if (w_slt)  o_alu_op = ALUOP_W'(4);
                else             o_alu_op = ALUOP_W'(0);
            end
            S_WB: begin
                o_rf_wr   = 1'b1;
                o_gpr_sel = (w_ori || w_lui) ? 2'd1 : 2'd0;
                o_retire  = 1'b1;
            end
            S_MA: begin
                o_ext_op = 2'd1;
                o_b_sel  = 1'b1;
            end
            S_MR: begin
                o_mem_req = 1'b1;
                o_mem_isd = 1'b1;
            end
            S_MEMWB: begin
                o_rf_wr   = 1'b1;
                o_gpr_sel = 2'd1;
                o_wd_sel  = 2'd1;
                o_retire  = 1'b1;
            end
            S_MW: begin
                o_mem_req = 1'b1;
                o_mem_isd = 1'b1;
                o_dm_wr   = 1'b1;
                o_retire  = i_mem_rdy;
            end
            S_BR: begin
                o_alu_op = ALUOP_W'(1);
                o_ext_op = 2'd1;
                o_npc_op = 2'd1;
                o_pc_wr  = w_bne ? !i_zero : i_zero;
                o_retire = 1'b1;
            end
            S_JMP: begin
                o_pc_wr   = 1'b1;
                o_npc_op  = w_jr ? 2'd3 : 2'd2;
                o_rf_wr   = w_jal;
                o_gpr_sel = w_jal ? 2'd2 : 2'd0;
                o_wd_sel  = w_jal ? 2'd2 : 2'd0;
                o_retire  = 1'b1;
            end
            default: ;
        endcase
        // Reset kills any in-flight request immediately, not at the next edge.
        if (rst) begin
            o_mem_req = 1'b0;
            o_mem_isd = 1'b0;
            o_pc_wr   = 1'b0;
            o_ir_wr   = 1'b0;
            o_rf_wr   = 1'b0;
            o_dm_wr   = 1'b0;
            o_ext_op  = 2'd0;
            o_alu_op  = '0;
            o_npc_op  = 2'd0;
            o_gpr_sel = 2'd0;
            o_wd_sel  = 2'd0;
            o_b_sel   = 1'b0;
            o_retire  = 1'b0;
            o_err     = 2'b00;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Scoreboard bench for mc_ctrl_hs: each stimulus cycle queues its expected
// output vector; a negedge monitor pops and compares.
module tb_mc_ctrl_hs;

    logic       clk = 1'b1;
    logic       rst = 1'b1;
    logic       zero = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       mem_rdy = 1'b0;
    logic       mem_req, mem_isd, pc_wr, ir_wr, rf_wr, dm_wr, b_sel, retire;
    logic [1:0] ext_op, npc_op, gpr_sel, wd_sel, err;
    logic [2:0] alu_op;

    int total = 0;
    int bad = 0;

    typedef struct {
        string       name;
        logic [20:0] exp;
    } exp_t;
    exp_t q[$];
    exp_t mon_t;
    logic [20:0] act;

    mc_ctrl_hs #(.ALUOP_W(3), .WAIT_MAX(15), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .i_zero(zero), .i_op(op), .i_funct(funct),
        .i_mem_rdy(mem_rdy), .o_mem_req(mem_req), .o_mem_isd(mem_isd),
        .o_pc_wr(pc_wr), .o_ir_wr(ir_wr), .o_rf_wr(rf_wr), .o_dm_wr(dm_wr),
        .o_ext_op(ext_op), .o_alu_op(alu_op), .o_npc_op(npc_op),
        .o_gpr_sel(gpr_sel), .o_wd_sel(wd_sel), .o_b_sel(b_sel),
        .o_retire(retire), .o_err(err)
    );

    always #5 clk = ~clk;

    // Vector: req isd pcw irw rfw dmw ext[2] alu[3] npc[2] gpr[2] wd[2] bsel ret err[2]
    function automatic logic [20:0] mk(input logic req, isd, pcw, irw, rfw, dmw,
                                       input logic [1:0] ext, input logic [2:0] alu,
                                       input logic [1:0] npc, gpr, wd,
                                       input logic bsel, ret, input logic [1:0] e);
        return {req, isd, pcw, irw, rfw, dmw, ext, alu, npc, gpr, wd, bsel, ret, e};
    endfunction

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_t = q.pop_front();
            act = {mem_req, mem_isd, pc_wr, ir_wr, rf_wr, dm_wr, ext_op, alu_op,
                   npc_op, gpr_sel, wd_sel, b_sel, retire, err};
            total++;
            if (act !== mon_t.exp) begin
                bad++;
                $display("FAIL %s: got %b want %b", mon_t.name, act, mon_t.exp);
            end
        end
    end

    task automatic cyc(input string name, input logic rdy, input logic z,
                       input logic [20:0] e);
        exp_t t;
        mem_rdy = rdy;
        zero    = z;
        t.name  = name;
        t.exp   = e;
        q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_dcd(input string name, input logic [5:0] o, input logic [5:0] f);
        op    = o;
        funct = f;
        cyc({name, "_fetch"}, 1'b1, 1'b0, mk(1,0,1,1,0,0, 0,0,0,0,0,0,0,0));
        cyc({name, "_dcd"},   1'b0, 1'b0, '0);
    endtask

    task automatic rtype(input string name, input logic [5:0] f, input logic [2:0] alu);
        fetch_dcd(name, 6'b000000, f);
        cyc({name, "_exe"}, 1'b1, 1'b0, mk(0,0,0,0,0,0, 0,alu,0,0,0,0,0,0));
        cyc({name, "_wb"},  1'b1, 1'b0, mk(0,0,0,0,1,0, 0,0,0,0,0,0,1,0));
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        cyc(name, 1'b0, 1'b0, '0);
        rst = 1'b0;
    endtask

    initial begin
        do_reset("reset");

        mem_rdy = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b1 || mem_isd !== 1'b0 || err !== 2'b00 ||
            pc_wr !== 1'b0 || ir_wr !== 1'b0 || retire !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: req=%b isd=%b err=%b pcw=%b irw=%b ret=%b",
                     mem_req, mem_isd, err, pc_wr, ir_wr, retire);
        end

        // ori $1,$0,0x8001 then addu $3,$1,$1, zero-wait memory
        fetch_dcd("ori", 6'b001101, 6'b000001);
        cyc("ori_exe", 1'b1, 1'b0, mk(0,0,0,0,0,0, 0,3,0,0,0,1,0,0));
        cyc("ori_wb",  1'b1, 1'b0, mk(0,0,0,0,1,0, 0,0,0,1,0,0,1,0));
        rtype("addu", 6'b100001, 3'd0);
        rtype("subu", 6'b100011, 3'd1);
        rtype("and",  6'b100100, 3'd2);
        rtype("or",   6'b100101, 3'd3);
        rtype("slt",  6'b101010, 3'd4);

        fetch_dcd("lui", 6'b001111, 6'b000000);
        cyc("lui_exe", 1'b1, 1'b0, mk(0,0,0,0,0,0, 2,5,0,0,0,1,0,0));
        cyc("lui_wb",  1'b1, 1'b0, mk(0,0,0,0,1,0, 0,0,0,1,0,0,1,0));

        // lw with three wait cycles in MR
        fetch_dcd("lw", 6'b100011, 6'b000000);
        cyc("lw_ma", 1'b0, 1'b0, mk(0,0,0,0,0,0, 1,0,0,0,0,1,0,0));
        for (int i = 0; i < 3; i++) cyc("lw_mr_wait", 1'b0, 1'b0, mk(1,1,0,0,0,0, 0,0,0,0,0,0,0,0));
        cyc("lw_mr_rdy", 1'b1, 1'b0, mk(1,1,0,0,0,0, 0,0,0,0,0,0,0,0));
        cyc("lw_memwb",  1'b1, 1'b0, mk(0,0,0,0,1,0, 0,0,0,1,1,0,1,0));

        // sw with three wait cycles in MW
        fetch_dcd("sw", 6'b101011, 6'b000000);
        cyc("sw_ma", 1'b0, 1'b0, mk(0,0,0,0,0,0, 1,0,0,0,0,1,0,0));
        for (int i = 0; i < 3; i++) cyc("sw_mw_wait", 1'b0, 1'b0, mk(1,1,0,0,0,1, 0,0,0,0,0,0,0,0));
        cyc("sw_mw_rdy", 1'b1, 1'b0, mk(1,1,0,0,0,1, 0,0,0,0,0,0,1,0));

        fetch_dcd("beq", 6'b000100, 6'b000000);
        cyc("beq_br_z1", 1'b1, 1'b1, mk(0,0,1,0,0,0, 1,1,1,0,0,0,1,0));
        fetch_dcd("beq0", 6'b000100, 6'b000000);
        cyc("beq_br_z0", 1'b1, 1'b0, mk(0,0,0,0,0,0, 1,1,1,0,0,0,1,0));
        fetch_dcd("bne", 6'b000101, 6'b000000);
        cyc("bne_br_z1", 1'b1, 1'b1, mk(0,0,0,0,0,0, 1,1,1,0,0,0,1,0));
        fetch_dcd("bne0", 6'b000101, 6'b000000);
        cyc("bne_br_z0", 1'b1, 1'b0, mk(0,0,1,0,0,0, 1,1,1,0,0,0,1,0));

        fetch_dcd("jal", 6'b000011, 6'b000000);
        cyc("jal_jmp", 1'b1, 1'b0, mk(0,0,1,0,1,0, 0,0,2,2,2,0,1,0));
        fetch_dcd("j", 6'b000010, 6'b000000);
        cyc("j_jmp", 1'b1, 1'b0, mk(0,0,1,0,0,0, 0,0,2,0,0,0,1,0));
        fetch_dcd("jr", 6'b000000, 6'b001000);
        cyc("jr_jmp", 1'b1, 1'b0, mk(0,0,1,0,0,0, 0,0,3,0,0,0,1,0));

        // rdy on the 15th FETCH cycle is still a success
        op = 6'b001101;
        for (int i = 0; i < 14; i++) cyc("fetch_wait", 1'b0, 1'b0, mk(1,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        cyc("fetch_rdy15", 1'b1, 1'b0, mk(1,0,1,1,0,0, 0,0,0,0,0,0,0,0));
        cyc("late_dcd", 1'b1, 1'b0, '0);
        cyc("late_exe", 1'b1, 1'b0, mk(0,0,0,0,0,0, 0,3,0,0,0,1,0,0));
        cyc("late_wb",  1'b1, 1'b0, mk(0,0,0,0,1,0, 0,0,0,1,0,0,1,0));

        // 15 cycles without rdy times out into TRAP
        for (int i = 0; i < 15; i++) cyc("fetch_to_wait", 1'b0, 1'b0, mk(1,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        total++;
        if (err !== 2'b10 || mem_req !== 1'b0 || retire !== 1'b0) begin
            bad++;
            $display("FAIL timeout_state: err=%b req=%b ret=%b", err, mem_req, retire);
        end
        for (int i = 0; i < 3; i++) cyc("trap_timeout", 1'b1, 1'b1, mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,2));
        do_reset("rst_after_timeout");
        cyc("fetch_after_to", 1'b0, 1'b0, mk(1,0,0,0,0,0, 0,0,0,0,0,0,0,0));

        // Illegal opcode and illegal R-type funct
        fetch_dcd("ill_op", 6'b111111, 6'b000000);
        for (int i = 0; i < 3; i++) cyc("trap_illegal", 1'b1, 1'b0, mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
        do_reset("rst_after_ill");
        fetch_dcd("ill_fn", 6'b000000, 6'b000000);
        cyc("trap_ill_fn", 1'b1, 1'b0, mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
        do_reset("rst_after_ill_fn");

        // Reset mid-MW must drop the request before the next clock edge
        fetch_dcd("sw_rst", 6'b101011, 6'b000000);
        cyc("sw_rst_ma", 1'b0, 1'b0, mk(0,0,0,0,0,0, 1,0,0,0,0,1,0,0));
        cyc("sw_rst_mw", 1'b0, 1'b0, mk(1,1,0,0,0,1, 0,0,0,0,0,0,0,0));
        rst = 1'b1;
        cyc("rst_in_mw", 1'b0, 1'b0, '0);
        rst = 1'b0;
        cyc("fetch_after_mw_rst", 1'b1, 1'b0, mk(1,0,1,1,0,0, 0,0,0,0,0,0,0,0));
        cyc("dcd_after_mw_rst", 1'b0, 1'b0, '0);
        cyc("ma_after_mw_rst",  1'b0, 1'b0, mk(0,0,0,0,0,0, 1,0,0,0,0,1,0,0));
        cyc("mw_after_mw_rst",  1'b1, 1'b0, mk(1,1,0,0,0,1, 0,0,0,0,0,0,1,0));

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
